// File: rtl/esp_sram_pkg.sv
// Shared helpers for the banked 1W1R SRAM wrapper: bank/row address split.
package esp_sram_pkg;

  // Address bits used to select a bank (0 when there is a single bank).
  function automatic int unsigned bank_bits(input int unsigned nbanks);
    return (nbanks > 1) ? $clog2(nbanks) : 0;
  endfunction

  // Width of the bank-index signal; at least 1 so the signal always exists.
  function automatic int unsigned bank_idx_width(input int unsigned nbanks);
    return (nbanks > 1) ? $clog2(nbanks) : 1;
  endfunction

  // Row address width inside one bank.
  function automatic int unsigned row_width(input int unsigned aw, input int unsigned nbanks);
    return aw - bank_bits(nbanks);
  endfunction

endpackage

// File: rtl/esp_sram_banked_wbuf_if.sv
// Write-port / read-port bundle of the banked 1W1R SRAM wrapper.
interface esp_sram_banked_wbuf_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 13
);
  logic                  CE0;
  logic [ADDR_WIDTH-1:0] A0;
  logic [DATA_WIDTH-1:0] D0;
  logic                  WE0;
  logic [DATA_WIDTH-1:0] WEM0;
  logic                  WREADY0;
  logic                  CE1;
  logic [ADDR_WIDTH-1:0] A1;
  logic [DATA_WIDTH-1:0] Q1;

  modport master (output CE0, A0, D0, WE0, WEM0, CE1, A1, input WREADY0, Q1);
  modport slave  (input CE0, A0, D0, WE0, WEM0, CE1, A1, output WREADY0, Q1);
endinterface

// File: rtl/esp_sram_sp_bank.sv
// Behavioural single-port bank with per-bit write mask and 1-cycle read.
// Replace with a technology macro wrapper of the same port list.
module esp_sram_sp_bank #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ROW_WIDTH  = 11
) (
  input  logic                  CLK,
  input  logic                  CE,
  input  logic [ROW_WIDTH-1:0]  A,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  WE,
  input  logic [DATA_WIDTH-1:0] WEM,
  output logic [DATA_WIDTH-1:0] Q
);
  logic [DATA_WIDTH-1:0] mem_q [2**ROW_WIDTH];
  logic [DATA_WIDTH-1:0] q_q;

  // One access per cycle: masked write or read; Q holds between reads.
  always_ff @(posedge CLK) begin
    if (CE) begin
      if (WE) mem_q[A] <= (mem_q[A] & ~WEM) | (D & WEM);
      else    q_q      <= mem_q[A];
    end
  end

  always_comb Q = q_q;
endmodule

// File: rtl/esp_sram_banked_wbuf.sv
// Banked 1W1R SRAM wrapper: reads always win the bank, conflicting writes are
// parked in an in-order write buffer that drains on free cycles and is
// bypassed to reads. Optional macro SRAM_CONFLICT_CNT_EN adds CONFLICT_CNT.
module esp_sram_banked_wbuf
  import esp_sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned NBANKS     = 4,
  parameter int unsigned WBUF_DEPTH = 2
) (
  input  logic CLK,
  input  logic RST,
  esp_sram_banked_wbuf_if.slave bus
`ifdef SRAM_CONFLICT_CNT_EN
  ,
  output logic [31:0] CONFLICT_CNT
`endif
);
  localparam int unsigned BB  = bank_bits(NBANKS);
  localparam int unsigned BIW = bank_idx_width(NBANKS);
  localparam int unsigned RW  = row_width(ADDR_WIDTH, NBANKS);
  localparam int unsigned CW  = $clog2(WBUF_DEPTH + 1);

  typedef logic [BIW-1:0] bank_t;
  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] mask;
  } wbuf_entry_t;

  function automatic bank_t bank_of(input logic [ADDR_WIDTH-1:0] addr);
    return (BB == 0) ? '0 : addr[BIW-1:0];
  endfunction

  function automatic logic [RW-1:0] row_of(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ADDR_WIDTH-1:BB];
  endfunction

  wbuf_entry_t           wbuf_q [WBUF_DEPTH];
  wbuf_entry_t           wbuf_d [WBUF_DEPTH];
  logic [CW-1:0]         count_q, count_d;
  bank_t                 rd_bank, wr_bank, head_bank, rd_bank_q;
  logic                  rd_act, drain, wready, wr_acc, direct, enq, rd_v_q;
  logic [DATA_WIDTH-1:0] byp_data, byp_mask, byp_data_q, byp_mask_q;
  logic [DATA_WIDTH-1:0] bank_rd, merged, q1_q;
  logic                  bank_ce  [NBANKS];
  logic                  bank_we  [NBANKS];
  logic [RW-1:0]         bank_a   [NBANKS];
  logic [DATA_WIDTH-1:0] bank_d   [NBANKS];
  logic [DATA_WIDTH-1:0] bank_wem [NBANKS];
  logic [DATA_WIDTH-1:0] bank_q   [NBANKS];

  // Arbitration: read owns its bank; a write goes direct only if the buffer is empty.
  always_comb begin
    rd_bank   = bank_of(bus.A1);
    wr_bank   = bank_of(bus.A0);
    head_bank = bank_of(wbuf_q[0].addr);
    rd_act    = bus.CE1 && !RST;
    drain     = !RST && (count_q != '0) && !(rd_act && head_bank == rd_bank);
    wready    = (count_q < CW'(WBUF_DEPTH)) || drain;
    wr_acc    = !RST && bus.CE0 && bus.WE0 && wready;
    direct    = wr_acc && (count_q == '0) && !(rd_act && wr_bank == rd_bank);
    enq       = wr_acc && !direct;
    bus.WREADY0 = wready;
  end

  // Bank port steering; by construction at most one source selects a bank.
  always_comb begin
    for (int unsigned b = 0; b < NBANKS; b++) begin
      bank_ce[b]  = 1'b0;
      bank_we[b]  = 1'b0;
      bank_a[b]   = '0;
      bank_d[b]   = '0;
      bank_wem[b] = '0;
      if (rd_act && rd_bank == BIW'(b)) begin
        bank_ce[b] = 1'b1;
        bank_a[b]  = row_of(bus.A1);
      end else if (direct && wr_bank == BIW'(b)) begin
        bank_ce[b]  = 1'b1;
        bank_we[b]  = 1'b1;
        bank_a[b]   = row_of(bus.A0);
        bank_d[b]   = bus.D0;
        bank_wem[b] = bus.WEM0;
      end else if (drain && head_bank == BIW'(b)) begin
        bank_ce[b]  = 1'b1;
        bank_we[b]  = 1'b1;
        bank_a[b]   = row_of(wbuf_q[0].addr);
        bank_d[b]   = wbuf_q[0].data;
        bank_wem[b] = wbuf_q[0].mask;
      end
    end
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    esp_sram_sp_bank #(.DATA_WIDTH(DATA_WIDTH), .ROW_WIDTH(RW)) u_bank (
      .CLK(CLK), .CE(bank_ce[b]), .A(bank_a[b]), .D(bank_d[b]),
      .WE(bank_we[b]), .WEM(bank_wem[b]), .Q(bank_q[b])
    );
  end

  // Write buffer as a shift queue: head at index 0, dequeue shifts before enqueue.
  always_comb begin
    wbuf_d  = wbuf_q;
    count_d = count_q;
    if (drain) begin
      for (int unsigned i = 0; i + 1 < WBUF_DEPTH; i++) wbuf_d[i] = wbuf_q[i+1];
      wbuf_d[WBUF_DEPTH-1] = '0;
      count_d = count_q - 1'b1;
    end
    if (enq) begin
      for (int unsigned i = 0; i < WBUF_DEPTH; i++)
        if (CW'(i) == count_d) wbuf_d[i] = '{valid: 1'b1, addr: bus.A0, data: bus.D0, mask: bus.WEM0};
      count_d = count_d + 1'b1;
    end
  end

  // Fold buffered hits oldest-to-youngest, then the same-cycle write on top.
  always_comb begin
    byp_data = '0;
    byp_mask = '0;
    for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
      if (wbuf_q[i].valid && wbuf_q[i].addr == bus.A1) begin
        byp_data = (byp_data & ~wbuf_q[i].mask) | (wbuf_q[i].data & wbuf_q[i].mask);
        byp_mask = byp_mask | wbuf_q[i].mask;
      end
    end
    if (wr_acc && bus.A0 == bus.A1) begin
      byp_data = (byp_data & ~bus.WEM0) | (bus.D0 & bus.WEM0);
      byp_mask = byp_mask | bus.WEM0;
    end
  end

  // Buffer state and registered read context.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < WBUF_DEPTH; i++) wbuf_q[i] <= '0;
      count_q    <= '0;
      rd_v_q     <= 1'b0;
      rd_bank_q  <= '0;
      byp_data_q <= '0;
      byp_mask_q <= '0;
      q1_q       <= '0;
    end else begin
      wbuf_q  <= wbuf_d;
      count_q <= count_d;
      rd_v_q  <= rd_act;
      if (rd_act) begin
        rd_bank_q  <= rd_bank;
        byp_data_q <= byp_data;
        byp_mask_q <= byp_mask;
      end
      if (rd_v_q) q1_q <= merged;
    end
  end

  // Final merge of bank data with bypass in the Q1 cycle; hold when no read.
  always_comb begin
    bank_rd = '0;
    for (int unsigned b = 0; b < NBANKS; b++)
      if (rd_bank_q == BIW'(b)) bank_rd = bank_q[b];
    merged = (bank_rd & ~byp_mask_q) | (byp_data_q & byp_mask_q);
    bus.Q1 = rd_v_q ? merged : q1_q;
  end

`ifdef SRAM_CONFLICT_CNT_EN
  logic [31:0] conflict_cnt_q;

  // Saturating count of cycles in which an accepted write had to be buffered.
  always_ff @(posedge CLK) begin
    if (RST)                                conflict_cnt_q <= '0;
    else if (enq && conflict_cnt_q != '1)   conflict_cnt_q <= conflict_cnt_q + 32'd1;
  end

  always_comb CONFLICT_CNT = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_esp_sram_banked_wbuf.sv
// Directed bench for esp_sram_banked_wbuf (NBANKS=4, WBUF_DEPTH=2).
module tb_esp_sram_banked_wbuf;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 13;
  localparam logic [DW-1:0] ONES = '1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  esp_sram_banked_wbuf_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
`ifdef SRAM_CONFLICT_CNT_EN
  logic [31:0] conflict_cnt;
`endif

  esp_sram_banked_wbuf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NBANKS(4), .WBUF_DEPTH(2)) dut (
    .CLK(clk), .RST(rst), .bus(bus)
`ifdef SRAM_CONFLICT_CNT_EN
    , .CONFLICT_CNT(conflict_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Drive one cycle's inputs at the falling edge, settle before any checks.
  task automatic cyc(input logic ce0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input logic [DW-1:0] wem0, input logic ce1, input logic [AW-1:0] a1);
    @(negedge clk);
    bus.CE0 = ce0; bus.WE0 = ce0; bus.A0 = a0; bus.D0 = d0; bus.WEM0 = wem0;
    bus.CE1 = ce1; bus.A1 = a1;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(); idle(); idle();
    @(negedge clk); rst = 1'b0; #1;
    n_vec++; if (bus.WREADY0 !== 1'b1) begin n_err++; $display("FAIL reset_wready: got %b want 1", bus.WREADY0); end
    n_vec++; if (bus.Q1 !== 64'h0) begin n_err++; $display("FAIL reset_q1: got %h want 0", bus.Q1); end
  endtask

  task automatic test_direct();
    cyc(1'b1, 13'h004, {4{16'hAAAA}}, ONES, 1'b1, 13'h001);
    n_vec++; if (bus.WREADY0 !== 1'b1) begin n_err++; $display("FAIL direct_wready: got %b want 1", bus.WREADY0); end
    cyc(1'b0, '0, '0, '0, 1'b1, 13'h004);
    idle();
    n_vec++; if (bus.Q1 !== {4{16'hAAAA}}) begin n_err++; $display("FAIL direct_rd: got %h want %h", bus.Q1, {4{16'hAAAA}}); end
    idle();
    n_vec++; if (bus.Q1 !== {4{16'hAAAA}}) begin n_err++; $display("FAIL q1_hold: got %h want %h", bus.Q1, {4{16'hAAAA}}); end
  endtask

  task automatic test_enqueue();
    cyc(1'b1, 13'h008, 64'h1234, ONES, 1'b1, 13'h00C);
    n_vec++; if (bus.WREADY0 !== 1'b1) begin n_err++; $display("FAIL enq_wready: got %b want 1", bus.WREADY0); end
    idle();
    n_vec++; if (bus.WREADY0 !== 1'b1) begin n_err++; $display("FAIL drain_wready: got %b want 1", bus.WREADY0); end
    cyc(1'b0, '0, '0, '0, 1'b1, 13'h008);
    idle();
    n_vec++; if (bus.Q1 !== 64'h1234) begin n_err++; $display("FAIL enq_rd: got %h want 1234", bus.Q1); end
  endtask

  task automatic test_bypass();
    cyc(1'b1, 13'h008, 64'h00FF, ONES, 1'b1, 13'h00C);
    cyc(1'b1, 13'h008, 64'hFF00, 64'hFF00, 1'b1, 13'h008);
    n_vec++; if (bus.WREADY0 !== 1'b1) begin n_err++; $display("FAIL byp_wready: got %b want 1", bus.WREADY0); end
    idle();
    n_vec++; if (bus.Q1 !== 64'hFFFF) begin n_err++; $display("FAIL byp_rd: got %h want ffff", bus.Q1); end
    idle();
    cyc(1'b0, '0, '0, '0, 1'b1, 13'h008);
    idle();
    n_vec++; if (bus.Q1 !== 64'hFFFF) begin n_err++; $display("FAIL byp_drained: got %h want ffff", bus.Q1); end
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, 13'h010, 64'd1, ONES, 1'b1, 13'h00C);
    n_vec++; if (bus.WREADY0 !== 1'b1) begin n_err++; $display("FAIL full_w1: got %b want 1", bus.WREADY0); end
    cyc(1'b1, 13'h014, 64'd2, ONES, 1'b1, 13'h00C);
    n_vec++; if (bus.WREADY0 !== 1'b1) begin n_err++; $display("FAIL full_w2: got %b want 1", bus.WREADY0); end
    cyc(1'b1, 13'h010, 64'd3, ONES, 1'b1, 13'h00C);
    n_vec++; if (bus.WREADY0 !== 1'b0) begin n_err++; $display("FAIL full_w3: got %b want 0", bus.WREADY0); end
    cyc(1'b1, 13'h010, 64'd3, ONES, 1'b0, '0);
    n_vec++; if (bus.WREADY0 !== 1'b1) begin n_err++; $display("FAIL full_release: got %b want 1", bus.WREADY0); end
    cyc(1'b0, '0, '0, '0, 1'b1, 13'h010);
    n_vec++; if (bus.WREADY0 !== 1'b0) begin n_err++; $display("FAIL full_blocked: got %b want 0", bus.WREADY0); end
    idle();
    n_vec++; if (bus.Q1 !== 64'd3) begin n_err++; $display("FAIL full_bypass: got %h want 3", bus.Q1); end
    idle();
    cyc(1'b0, '0, '0, '0, 1'b1, 13'h010);
    cyc(1'b0, '0, '0, '0, 1'b1, 13'h014);
    n_vec++; if (bus.Q1 !== 64'd3) begin n_err++; $display("FAIL full_final010: got %h want 3", bus.Q1); end
    idle();
    n_vec++; if (bus.Q1 !== 64'd2) begin n_err++; $display("FAIL full_final014: got %h want 2", bus.Q1); end
  endtask

  task automatic test_reset_midop();
    cyc(1'b1, 13'h020, 64'h11, ONES, 1'b1, 13'h001);
    cyc(1'b1, 13'h020, 64'h55, ONES, 1'b1, 13'h024);
    cyc(1'b1, 13'h020, 64'h66, ONES, 1'b1, 13'h024);
    @(negedge clk);
    rst = 1'b1;
    bus.CE0 = 1'b0; bus.WE0 = 1'b0; bus.CE1 = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    n_vec++; if (bus.WREADY0 !== 1'b1) begin n_err++; $display("FAIL midrst_wready: got %b want 1", bus.WREADY0); end
    n_vec++; if (bus.Q1 !== 64'h0) begin n_err++; $display("FAIL midrst_q1: got %h want 0", bus.Q1); end
    idle(); idle();
    n_vec++; if (bus.Q1 !== 64'h0) begin n_err++; $display("FAIL midrst_q1_idle: got %h want 0", bus.Q1); end
    cyc(1'b0, '0, '0, '0, 1'b1, 13'h020);
    idle();
    n_vec++; if (bus.Q1 !== 64'h11) begin n_err++; $display("FAIL midrst_discard: got %h want 11", bus.Q1); end
  endtask

`ifdef SRAM_CONFLICT_CNT_EN
  task automatic test_conflict_cnt();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 13'h040, 64'(i), ONES, 1'b1, 13'h044);
      idle();
    end
    n_vec++; if (conflict_cnt !== 32'd5) begin n_err++; $display("FAIL cnt_five: got %0d want 5", conflict_cnt); end
    @(negedge clk);
    dut.conflict_cnt_q = 32'hFFFF_FFFF;
    cyc(1'b1, 13'h040, 64'h9, ONES, 1'b1, 13'h044);
    idle();
    n_vec++; if (conflict_cnt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL cnt_sat: got %h want ffffffff", conflict_cnt); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.CE0 = 1'b0; bus.WE0 = 1'b0; bus.A0 = '0; bus.D0 = '0; bus.WEM0 = '0;
    bus.CE1 = 1'b0; bus.A1 = '0;
    test_reset();
    test_direct();
    test_enqueue();
    test_bypass();
    test_back_to_back();
    test_reset_midop();
`ifdef SRAM_CONFLICT_CNT_EN
    test_conflict_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end
endmodule
